// File: rtl/reg_bank_arbiter_pkg.sv
// rtl/reg_bank_arbiter_pkg.sv - shared encodings and defaults for reg_bank_arbiter
// Build option REGARB_FIXED_PRIO_EN is consumed by rr_pick2.
package reg_bank_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic REQ_ID_CORE = 1'b0;
  localparam logic REQ_ID_DBG  = 1'b1;

endpackage

// File: rtl/reg_bank_arbiter_rr_pick2.sv
// rtl/reg_bank_arbiter_rr_pick2.sv - two-way round-robin chooser (pure combinational)
// REGARB_FIXED_PRIO_EN: requester 0 always wins a tie and last is ignored.
module rr_pick2
  import reg_bank_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

`ifdef REGARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    gnt_valid = |req;
    gnt_id    = req[0] ? REQ_ID_CORE : REQ_ID_DBG;
  end
`else
  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ_ID_CORE;
    // On a tie the requester not granted last time goes next.
    if (req == 2'b11)
      gnt_id = ~last;
    else if (req[1])
      gnt_id = REQ_ID_DBG;
  end
`endif

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - serialises two requesters onto one combinational register bank
// Tie-breaking is round-robin unless REGARB_FIXED_PRIO_EN is defined (see rr_pick2).
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] RA1_0,
  input  logic [ADDR_W-1:0] RA2_0,
  input  logic [ADDR_W-1:0] RA1_1,
  input  logic [ADDR_W-1:0] RA2_1,
  input  logic [ADDR_W-1:0] WA0,
  input  logic [ADDR_W-1:0] WA1,
  input  logic [DATA_W-1:0] WD0,
  input  logic [DATA_W-1:0] WD1,
  output logic              ACK0,
  output logic              ACK1,
  output logic [DATA_W-1:0] RD1_0,
  output logic [DATA_W-1:0] RD2_0,
  output logic [DATA_W-1:0] RD1_1,
  output logic [DATA_W-1:0] RD2_1,
  output logic [ADDR_W-1:0] AR1,
  output logic [ADDR_W-1:0] AR2,
  output logic [ADDR_W-1:0] AW,
  output logic              REG_WRITE,
  output logic [DATA_W-1:0] DIN,
  input  logic [DATA_W-1:0] DR1,
  input  logic [DATA_W-1:0] DR2
);

  state_t state;
  logic   last;
  logic   win;
  logic   l_we;
  logic   gnt_valid;
  logic   gnt_id;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_ra1;
  logic [ADDR_W-1:0] sel_ra2;
  logic [ADDR_W-1:0] sel_wa;
  logic [DATA_W-1:0] sel_wd;

  rr_pick2 u_pick (
    .req       ({REQ1, REQ0}),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    sel_we  = WE0;
    sel_ra1 = RA1_0;
    sel_ra2 = RA2_0;
    sel_wa  = WA0;
    sel_wd  = WD0;
    if (gnt_id == REQ_ID_DBG) begin
      sel_we  = WE1;
      sel_ra1 = RA1_1;
      sel_ra2 = RA2_1;
      sel_wa  = WA1;
      sel_wd  = WD1;
    end
  end

  // The bank-facing address/data registers double as the latched request,
  // so they hold their value outside ACCESS and never glitch the bank.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      last      <= REQ_ID_DBG;
      win       <= REQ_ID_CORE;
      l_we      <= 1'b0;
      ACK0      <= 1'b0;
      ACK1      <= 1'b0;
      RD1_0     <= '0;
      RD2_0     <= '0;
      RD1_1     <= '0;
      RD2_1     <= '0;
      AR1       <= '0;
      AR2       <= '0;
      AW        <= '0;
      DIN       <= '0;
      REG_WRITE <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            win       <= gnt_id;
            l_we      <= sel_we;
            AR1       <= sel_ra1;
            AR2       <= sel_ra2;
            AW        <= sel_wa;
            DIN       <= sel_wd;
            REG_WRITE <= sel_we && (sel_wa != '0);
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          REG_WRITE <= 1'b0;
          if (!l_we) begin
            if (win == REQ_ID_DBG) begin
              RD1_1 <= DR1;
              RD2_1 <= DR2;
            end else begin
              RD1_0 <= DR1;
              RD2_0 <= DR2;
            end
          end
          ACK0  <= (win == REQ_ID_CORE);
          ACK1  <= (win == REQ_ID_DBG);
          state <= ST_DONE;
        end
        ST_DONE: begin
          ACK0  <= 1'b0;
          ACK1  <= 1'b0;
          last  <= win;
          state <= ST_IDLE;
        end
        default: begin
          REG_WRITE <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - self-checking bench for reg_bank_arbiter with a behavioural bank model
// Honours REGARB_FIXED_PRIO_EN when checking tie-breaking.
module tb_reg_bank_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0, REQ1, WE0, WE1;
  logic [4:0]  RA1_0, RA2_0, RA1_1, RA2_1, WA0, WA1;
  logic [31:0] WD0, WD1;
  logic        ACK0, ACK1;
  logic [31:0] RD1_0, RD2_0, RD1_1, RD2_1;
  logic [4:0]  AR1, AR2, AW;
  logic        REG_WRITE;
  logic [31:0] DIN, DR1, DR2;

  logic [31:0] bank [32];
  logic [31:0] init_vals [32];
  logic        init_bank;
  int          wr_cycles = 0;

  logic [31:0] model [32];
  logic [31:0] exp_rd1 [2];
  logic [31:0] exp_rd2 [2];

  int errs = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  reg_bank_arbiter dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .RA1_0(RA1_0), .RA2_0(RA2_0), .RA1_1(RA1_1), .RA2_1(RA2_1),
    .WA0(WA0), .WA1(WA1), .WD0(WD0), .WD1(WD1), .ACK0(ACK0), .ACK1(ACK1),
    .RD1_0(RD1_0), .RD2_0(RD2_0), .RD1_1(RD1_1), .RD2_1(RD2_1),
    .AR1(AR1), .AR2(AR2), .AW(AW), .REG_WRITE(REG_WRITE), .DIN(DIN),
    .DR1(DR1), .DR2(DR2)
  );

  assign DR1 = bank[AR1];
  assign DR2 = bank[AR2];

  always @(posedge CLK) begin
    if (init_bank) begin
      for (int i = 0; i < 32; i++) bank[i] <= init_vals[i];
    end else if (REG_WRITE) begin
      bank[AW]  <= DIN;
      wr_cycles <= wr_cycles + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input logic req, input logic we, input logic [4:0] ra1,
                       input logic [4:0] ra2, input logic [4:0] wa, input logic [31:0] wd);
    if (id == 0) begin
      REQ0 = req; WE0 = we; RA1_0 = ra1; RA2_0 = ra2; WA0 = wa; WD0 = wd;
    end else begin
      REQ1 = req; WE1 = we; RA1_1 = ra1; RA2_1 = ra2; WA1 = wa; WD1 = wd;
    end
  endtask

  task automatic check_rd(input string tag);
    chk({tag, "_rd1_0"}, RD1_0, exp_rd1[0]);
    chk({tag, "_rd2_0"}, RD2_0, exp_rd2[0]);
    chk({tag, "_rd1_1"}, RD1_1, exp_rd1[1]);
    chk({tag, "_rd2_1"}, RD2_1, exp_rd2[1]);
  endtask

  // One isolated access from IDLE; called at a negedge with the DUT idle.
  task automatic access(input int id, input logic we, input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic [4:0] wa, input logic [31:0] wd, input bit pulse);
    int  wc0;
    bit  do_wr;
    do_wr = we && (wa != 5'd0);
    wc0 = wr_cycles;
    drive(id, 1'b1, we, ra1, ra2, wa, wd);
    @(posedge CLK);
    @(negedge CLK);
    chk("access_ar1", AR1, ra1);
    chk("access_ar2", AR2, ra2);
    chk("access_aw", AW, wa);
    chk("access_din", DIN, wd);
    chk("access_reg_write", REG_WRITE, do_wr);
    chk("access_ack_early", {ACK1, ACK0}, 2'b00);
    // Later field changes (or a dropped REQ) must not disturb the latched access.
    if (pulse) drive(id, 1'b0, ~we, ~ra1, ~ra2, ~wa, ~wd);
    @(negedge CLK);
    chk("done_ack0", ACK0, id == 0);
    chk("done_ack1", ACK1, id == 1);
    chk("done_reg_write", REG_WRITE, 1'b0);
    if (!we) begin
      exp_rd1[id] = model[ra1];
      exp_rd2[id] = model[ra2];
    end else if (wa != 5'd0) begin
      model[wa] = wd;
    end
    check_rd("done");
    drive(id, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge CLK);
    chk("idle_ack", {ACK1, ACK0}, 2'b00);
    chk("write_cycles", wr_cycles - wc0, do_wr ? 1 : 0);
  endtask

  initial begin
    int   winner;
    logic [31:0] r0_orig;
    RST = 1'b1;
    init_bank = 1'b1;
    drive(0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int i = 0; i < 32; i++) init_vals[i] = $urandom;
    init_vals[3] = 32'h11;
    init_vals[4] = 32'h22;
    for (int i = 0; i < 32; i++) model[i] = init_vals[i];
    r0_orig = init_vals[0];
    for (int i = 0; i < 2; i++) begin exp_rd1[i] = '0; exp_rd2[i] = '0; end
    @(negedge CLK);
    @(negedge CLK);
    init_bank = 1'b0;
    chk("rst_ack", {ACK1, ACK0}, 2'b00);
    chk("rst_reg_write", REG_WRITE, 1'b0);
    chk("rst_bus", {AR1, AR2, AW, DIN}, '0);
    check_rd("rst");
    RST = 1'b0;
    @(negedge CLK);

    // Basic read of r3/r4 by the core.
    access(0, 1'b0, 5'd3, 5'd4, 5'd0, 32'd0, 1'b0);
    chk("read_r3", RD1_0, 32'h11);
    chk("read_r4", RD2_0, 32'h22);

    // Debug write then core read of the same register.
    access(1, 1'b1, 5'd0, 5'd0, 5'd7, 32'hDEADBEEF, 1'b0);
    access(0, 1'b0, 5'd7, 5'd3, 5'd0, 32'd0, 1'b0);
    chk("read_after_write", RD1_0, 32'hDEADBEEF);

    // Register 0 is immutable.
    access(0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h5, 1'b0);
    access(1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    chk("r0_immutable", RD1_1, r0_orig);

    // Single-cycle request pulse still completes.
    access(0, 1'b0, 5'd4, 5'd3, 5'd0, 32'd0, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    chk("pulse_no_repeat", {ACK1, ACK0}, 2'b00);

    for (int n = 0; n < 16; n++) begin
      access($urandom_range(0, 1), 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
             5'($urandom), $urandom, 1'($urandom_range(0, 1)));
    end

    // Core access leaves last-grant = 0; then reset in the middle of a debug write.
    access(0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0);
    drive(1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9, 32'hA5A5_5A5A);
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_reg_write_pre", REG_WRITE, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk("abort_reg_write_async", REG_WRITE, 1'b0);
    chk("abort_bus", {AR1, AR2, AW, DIN}, '0);
    drive(1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin exp_rd1[i] = '0; exp_rd2[i] = '0; end
    check_rd("abort");
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_no_ack", {ACK1, ACK0}, 2'b00);
    chk("abort_no_write", bank[9], model[9]);
    RST = 1'b0;

    // Continuous tie: acks every third cycle, alternating from requester 0.
    drive(0, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 32'd0);
    drive(1, 1'b1, 1'b0, 5'd7, 5'd1, 5'd0, 32'd0);
    winner = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      if (c % 3 == 2) begin
        chk("rr_ack0", ACK0, winner == 0);
        chk("rr_ack1", ACK1, winner == 1);
        exp_rd1[winner] = model[winner == 0 ? 3 : 7];
        exp_rd2[winner] = model[winner == 0 ? 4 : 1];
        check_rd("rr");
`ifndef REGARB_FIXED_PRIO_EN
        winner = 1 - winner;
`endif
      end else begin
        chk("rr_ack_idle", {ACK1, ACK0}, 2'b00);
      end
    end
    drive(0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (4) @(negedge CLK);
    chk("final_reg_write", REG_WRITE, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
